// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared FSM state encoding and mode constants for mem_dma
package mem_dma_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/mem_dma_if.sv
// mem_dma_if: data memory port (addr/din/we out, combinational dout back)
// master: the initiator driving addr/din/we; slave: the memory answering with dout
interface mem_dma_if #(parameter int AW = 8);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic [7:0]    mem_dout;
  modport master (output mem_addr, mem_din, mem_we, input mem_dout);
  modport slave  (input mem_addr, mem_din, mem_we, output mem_dout);
endinterface

// File: rtl/mem_dma.sv
// mem_dma: byte copy/fill initiator that owns the data memory port while busy
// Ports: clk, rst (async, active-high); start/mode/src/dst/len/fill_val request,
// latched when start is accepted in IDLE; busy while transferring; done one-cycle pulse;
// mem (mem_dma_if.master) memory port. Optional MEM_DMA_CHECKSUM_EN adds an 8-bit
// checksum output summing every written byte of the last transfer.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [7:0]    fill_val,
  output logic          busy,
  output logic          done,
`ifdef MEM_DMA_CHECKSUM_EN
  output logic [7:0]    checksum,
`endif
  mem_dma_if.master     mem
);
  state_t        state, state_nx;
  logic          mode_r;
  logic [AW-1:0] src_r, dst_r, len_r, i;
  logic [7:0]    fill_r, data_r;
  logic [AW-1:0] i_nx;
  logic [7:0]    wr_data;
  logic          accept;
  assign i_nx    = i + AW'(1);
  assign wr_data = mode_r == MODE_COPY ? data_r : fill_r;
  assign accept  = state == IDLE && start;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_r <= MODE_COPY;
      src_r  <= '0;
      dst_r  <= '0;
      len_r  <= '0;
      fill_r <= '0;
      data_r <= '0;
      i      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mode_r <= mode;
        src_r  <= src;
        dst_r  <= dst;
        len_r  <= len;
        fill_r <= fill_val;
        i      <= '0;
      end
      if (state == RD) data_r <= mem.mem_dout;
      if (state == WR) i <= i_nx;
    end
  end
`ifdef MEM_DMA_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum <= '0;
    else if (accept) checksum <= '0;
    else if (state == WR) checksum <= checksum + wr_data;
  end
`endif
  always_comb begin
    state_nx     = state;
    busy         = state == RD || state == WR;
    done         = state == DONE;
    mem.mem_we   = state == WR;
    mem.mem_addr = state == RD ? src_r + i : state == WR ? dst_r + i : '0;
    mem.mem_din  = state == WR ? wr_data : '0;
    case (state)
      IDLE: state_nx = !start ? IDLE : len == '0 ? DONE : mode == MODE_COPY ? RD : WR;
      RD:   state_nx = WR;
      WR:   state_nx = i_nx == len_r ? DONE : mode_r == MODE_COPY ? RD : WR;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: scoreboard bench for mem_dma with a behavioural byte memory as responder
module tb_mem_dma;
  import mem_dma_pkg::*;
  logic       clk = 0, rst = 1, start = 0, mode = 0;
  logic [7:0] src = 0, dst = 0, len = 0, fill_val = 0;
  logic       busy, done;
`ifdef MEM_DMA_CHECKSUM_EN
  logic [7:0] checksum;
`endif
  mem_dma_if #(.AW(8)) bus();
  mem_dma #(.AW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done),
`ifdef MEM_DMA_CHECKSUM_EN
    .checksum(checksum),
`endif
    .mem(bus)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] mem [256];
  logic       ld = 0;
  logic [7:0] ld_a = 0, ld_v = 0;
  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    else if (ld) mem[ld_a] <= ld_v;
  assign bus.mem_dout = mem[bus.mem_addr];
  typedef struct {bit d; logic [7:0] a; logic [7:0] v; int t;} ev_t;
  ev_t q[$];
  ev_t me;
  int checks = 0, errors = 0, base = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  task automatic exp_w(logic [7:0] a, logic [7:0] v, int k);
    q.push_back('{1'b0, a, v, base + k});
  endtask
  task automatic exp_d(int k);
    q.push_back('{1'b1, 8'h00, 8'h00, base + k});
  endtask
  always @(negedge clk)
    if (!rst && (bus.mem_we || done)) begin
      if (q.size() == 0) chk("unexpected_output", {30'd0, bus.mem_we, done}, 0);
      else begin
        me = q.pop_front();
        chk("event_kind", {31'd0, done}, {31'd0, me.d});
        chk("event_cycle", cyc, me.t);
        if (!me.d) begin
          chk("wr_addr", bus.mem_addr, me.a);
          chk("wr_data", bus.mem_din, me.v);
          chk("wr_busy", busy, 1);
        end else chk("done_busy", busy, 0);
      end
    end
  task automatic arm();
    @(negedge clk);
    base = cyc;
  endtask
  task automatic fire(logic m, logic [7:0] s, logic [7:0] d, logic [7:0] l, logic [7:0] f);
    mode = m; src = s; dst = d; len = l; fill_val = f; start = 1;
    @(negedge clk);
    start = 0; mode = ~m; src = ~s; dst = ~d; len = ~l; fill_val = ~f;
  endtask
  task automatic drain();
    for (int k = 0; k < 100 && (q.size() != 0 || busy); k++) @(negedge clk);
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask
  task automatic poke(logic [7:0] a, logic [7:0] v);
    @(negedge clk);
    ld_a = a; ld_v = v; ld = 1;
    @(negedge clk);
    ld = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_din", bus.mem_din, 0);
    @(negedge clk) rst = 0;
    poke(8'h0F, 8'hC3);
    poke(8'h14, 8'hC3);
    arm();
    for (int k = 0; k < 4; k++) exp_w(8'h10 + 8'(k), 8'hA5, k + 1);
    exp_d(5);
    fire(MODE_FILL, 8'h00, 8'h10, 8'd4, 8'hA5);
    drain();
    for (int k = 0; k < 4; k++) chk("fill_mem", mem[8'h10 + 8'(k)], 8'hA5);
    chk("fill_below", mem[8'h0F], 8'hC3);
    chk("fill_above", mem[8'h14], 8'hC3);
    poke(8'h20, 8'h11);
    poke(8'h21, 8'h22);
    poke(8'h22, 8'h33);
    arm();
    exp_w(8'h40, 8'h11, 2);
    exp_w(8'h41, 8'h22, 4);
    exp_w(8'h42, 8'h33, 6);
    exp_d(7);
    fire(MODE_COPY, 8'h20, 8'h40, 8'd3, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      chk("copy_busy", busy, k <= 6 ? 1 : 0);
      @(negedge clk);
    end
    drain();
    chk("copy_mem0", mem[8'h40], 8'h11);
    chk("copy_mem1", mem[8'h41], 8'h22);
    chk("copy_mem2", mem[8'h42], 8'h33);
    poke(8'h01, 8'hC3);
    arm();
    exp_w(8'hFE, 8'h5A, 1);
    exp_w(8'hFF, 8'h5A, 2);
    exp_w(8'h00, 8'h5A, 3);
    exp_d(4);
    fire(MODE_FILL, 8'h00, 8'hFE, 8'd3, 8'h5A);
    drain();
    chk("wrap_fe", mem[8'hFE], 8'h5A);
    chk("wrap_ff", mem[8'hFF], 8'h5A);
    chk("wrap_00", mem[8'h00], 8'h5A);
    chk("wrap_01", mem[8'h01], 8'hC3);
    poke(8'h90, 8'h12);
    arm();
    exp_d(1);
    fire(MODE_FILL, 8'h00, 8'h90, 8'd0, 8'hEE);
    drain();
    chk("len0_mem", mem[8'h90], 8'h12);
    arm();
    exp_w(8'h44, 8'h11, 2);
    exp_w(8'h45, 8'h22, 4);
    exp_w(8'h46, 8'h33, 6);
    exp_d(7);
    fire(MODE_COPY, 8'h20, 8'h44, 8'd3, 8'h00);
    @(negedge clk);
    mode = MODE_FILL; dst = 8'h00; len = 8'd0; start = 1;
    @(negedge clk);
    start = 0;
    drain();
    poke(8'h50, 8'h01);
    poke(8'h51, 8'h02);
    poke(8'h52, 8'h03);
    for (int k = 0; k < 3; k++) poke(8'h60 + 8'(k), 8'hEE);
    arm();
    exp_w(8'h60, 8'h01, 2);
    exp_w(8'h61, 8'h02, 4);
    fire(MODE_COPY, 8'h50, 8'h60, 8'd8, 8'h00);
    while (cyc < base + 5) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("abort_we", bus.mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk) rst = 0;
    drain();
    chk("abort_mem0", mem[8'h60], 8'h01);
    chk("abort_mem1", mem[8'h61], 8'h02);
    chk("abort_mem2", mem[8'h62], 8'hEE);
    arm();
    exp_w(8'h80, 8'h77, 1);
    exp_w(8'h81, 8'h77, 2);
    exp_d(3);
    fire(MODE_FILL, 8'h00, 8'h80, 8'd2, 8'h77);
    drain();
    chk("restart_mem", mem[8'h81], 8'h77);
    poke(8'h30, 8'h7E);
    for (int k = 1; k < 4; k++) poke(8'h30 + 8'(k), 8'h99);
    arm();
    exp_w(8'h31, 8'h7E, 2);
    exp_w(8'h32, 8'h7E, 4);
    exp_w(8'h33, 8'h7E, 6);
    exp_d(7);
    fire(MODE_COPY, 8'h30, 8'h31, 8'd3, 8'h00);
    drain();
    for (int k = 1; k < 4; k++) chk("overlap_mem", mem[8'h30 + 8'(k)], 8'h7E);
    arm();
    for (int k = 0; k < 3; k++) exp_w(8'hB0 + 8'(k), 8'h40, k + 1);
    exp_d(4);
    fire(MODE_FILL, 8'h00, 8'hB0, 8'd3, 8'h40);
    drain();
`ifdef MEM_DMA_CHECKSUM_EN
    chk("checksum_3x40", checksum, 8'hC0);
`endif
    arm();
    for (int k = 0; k < 4; k++) exp_w(8'hA0 + 8'(k), 8'h40, k + 1);
    exp_d(5);
    fire(MODE_FILL, 8'h00, 8'hA0, 8'd4, 8'h40);
    drain();
`ifdef MEM_DMA_CHECKSUM_EN
    chk("checksum_4x40", checksum, 8'h00);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
